// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, serial 1-bit-per-cycle shifter,
// valid/ready handshakes on operand intake and result delivery.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            is_shift;
  logic [XLEN-1:0] acc_sh;
  logic [SHW-1:0]  shamt;

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (alu_ctrl)
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_ADD: alu_res = op_a + op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit step in the direction/fill of the latched shift op.
  always_comb begin
    case (ctrl_q)
      OP_SLL:  acc_sh = {acc_q[XLEN-2:0], 1'b0};
      OP_SRL:  acc_sh = {1'b0, acc_q[XLEN-1:1]};
      default: acc_sh = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ctrl_d = alu_ctrl;
          if (is_shift) begin
            acc_d = op_a;
            cnt_d = shamt;
            if (shamt == '0) begin
              result_d  = op_a;
              zero_d    = (op_a == '0);
              illegal_d = 1'b0;
              state_d   = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        cnt_d = cnt_q - SHW'(1);
        // Last step lands straight in the result register to save a cycle.
        if (cnt_q == SHW'(1)) begin
          result_d  = acc_sh;
          zero_d    = (acc_sh == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: handshakes, latencies, shifts, backpressure, reset abort.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, result;
  logic        zero, illegal;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op in a negedge slot, then scramble inputs and count edges to out_valid.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    @(negedge clk);
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; alu_ctrl = 4'b0010; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    l = 1;
    @(negedge clk);
    while (!out_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
    chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    chk("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("in_ready_return", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    rst = 1'b0;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    chk("add_lat", lat, 32'd1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_zero", {31'b0, zero}, 32'd0);
    drain();

    issue(4'b0110, 32'd5, 32'd5, lat);
    chk("sub_lat", lat, 32'd1);
    chk("sub_res", result, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    drain();

    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("slt_neg_res", result, 32'd1);
    drain();
    issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, lat);
    chk("slt_swap_res", result, 32'd0);
    chk("slt_swap_zero", {31'b0, zero}, 32'd1);
    drain();

    issue(4'b1000, 32'h8000_0000, 32'h0000_001F, lat);
    chk("sra_lat", lat, 32'd32);
    chk("sra_res", result, 32'hFFFF_FFFF);
    chk("sra_illegal", {31'b0, illegal}, 32'd0);
    drain();

    issue(4'b0101, 32'h8000_0000, 32'h0000_001F, lat);
    chk("srl_lat", lat, 32'd32);
    chk("srl_res", result, 32'h0000_0001);
    drain();

    issue(4'b0100, 32'h0000_0001, 32'h0000_0020, lat);
    chk("sll0_lat", lat, 32'd1);
    chk("sll0_res", result, 32'h0000_0001);
    drain();

    issue(4'b0100, 32'h0000_0003, 32'hFFFF_FFE4, lat);
    chk("sll4_lat", lat, 32'd5);
    chk("sll4_res", result, 32'h0000_0030);
    drain();

    issue(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", result, 32'h0F0F_F0F0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      if (i < 4) @(negedge clk);
    end
    drain();

    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    chk("ill_lat", lat, 32'd1);
    chk("ill_res", result, 32'd0);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_zero", {31'b0, zero}, 32'd1);
    drain();

    issue(4'b0000, 32'h0000_00FF, 32'h0000_000F, lat);
    chk("and_res", result, 32'h0000_000F);
    chk("and_illegal", {31'b0, illegal}, 32'd0);
    chk("and_zero", {31'b0, zero}, 32'd0);
    drain();

    // Abort a 20-step shift with reset three cycles after accept.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0100; op_a = 32'd1; op_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_shift", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'b0, out_valid}, 32'd0);
    end
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);

    issue(4'b0010, 32'd2, 32'd3, lat);
    chk("post_rst_add_lat", lat, 32'd1);
    chk("post_rst_add_res", result, 32'd5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
